// File: rtl/bp_fe_pkg.sv
// Shared types for the front-end cache-request arbiter: FSM state encoding and pointer sizing helper.
// Purely declarative; no latency or backpressure of its own.
package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_arb_idle,
    e_arb_meta,
    e_arb_wait
  } bp_fe_arb_state_e;

  // Index width that stays at least one bit wide for a single-entry range.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Rotating-priority pick over v_i starting at the stored pointer; 0-cycle pick, pointer advances past the winner.
// The pointer only moves on yumi_i, so a stalled pick keeps its priority order until it is accepted.
module bsg_arb_round_robin
  import bp_fe_pkg::*;
#(
  parameter int reqs_p = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [reqs_p-1:0]                v_i,
  input  logic                             yumi_i,
  output logic [safe_clog2(reqs_p)-1:0]    pick_o,
  output logic                             v_o
);

  localparam int ptr_w_lp = safe_clog2(reqs_p);

  logic [ptr_w_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [ptr_w_lp:0]   idx_sum;

  // Wrap is a single subtract because ptr + k never reaches 2*reqs_p.
  always_comb begin
    pick_o  = '0;
    v_o     = 1'b0;
    idx_sum = '0;
    for (int k = 0; k < reqs_p; k++) begin
      idx_sum = {1'b0, rr_ptr_q} + (ptr_w_lp+1)'(k);
      if (idx_sum >= (ptr_w_lp+1)'(reqs_p)) begin
        idx_sum = idx_sum - (ptr_w_lp+1)'(reqs_p);
      end
      if (!v_o && v_i[idx_sum[ptr_w_lp-1:0]]) begin
        v_o    = 1'b1;
        pick_o = idx_sum[ptr_w_lp-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (yumi_i) begin
      rr_ptr_d = (pick_o == ptr_w_lp'(reqs_p-1)) ? '0 : pick_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/bp_fe_cache_req_arbiter.sv
// Shares one I$ engine request port among reqs_p requesters; request issue is 0-cycle, grant held until engine complete.
// Issue is blocked by engine busy / no credit and by any transaction in flight; status pulses go to the granted port only.
module bp_fe_cache_req_arbiter
  import bp_fe_pkg::*;
#(
  parameter int reqs_p           = 2,
  parameter int req_width_p      = 8,
  parameter int metadata_width_p = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [reqs_p*req_width_p-1:0]      req_i,
  input  logic [reqs_p-1:0]                  req_v_i,
  output logic [reqs_p-1:0]                  req_ready_and_o,
  input  logic [reqs_p*metadata_width_p-1:0] req_metadata_i,
  input  logic [reqs_p-1:0]                  req_metadata_v_i,
  output logic [reqs_p-1:0]                  req_busy_o,
  output logic [reqs_p-1:0]                  req_critical_tag_o,
  output logic [reqs_p-1:0]                  req_critical_data_o,
  output logic [reqs_p-1:0]                  req_complete_o,
  output logic [req_width_p-1:0]             cache_req_o,
  output logic                               cache_req_v_o,
  input  logic                               cache_req_ready_and_i,
  input  logic                               cache_req_busy_i,
  output logic [metadata_width_p-1:0]        cache_req_metadata_o,
  output logic                               cache_req_metadata_v_o,
  input  logic                               cache_req_critical_tag_i,
  input  logic                               cache_req_critical_data_i,
  input  logic                               cache_req_complete_i,
  input  logic                               cache_req_credits_full_i
);

  localparam int ptr_w_lp = safe_clog2(reqs_p);

  bp_fe_arb_state_e      state_q, state_d;
  logic [ptr_w_lp-1:0]   grant_q, grant_d;
  logic [ptr_w_lp-1:0]   pick;
  logic                  pick_v;
  logic                  yumi;
  logic                  issue_ok;
  logic [reqs_p-1:0]     pick_oh, grant_oh;

  logic [req_width_p-1:0]      req_arr [reqs_p];
  logic [metadata_width_p-1:0] md_arr  [reqs_p];

  for (genvar i = 0; i < reqs_p; i++) begin : g_unpack
    assign req_arr[i] = req_i[i*req_width_p +: req_width_p];
    assign md_arr[i]  = req_metadata_i[i*metadata_width_p +: metadata_width_p];
  end

  bsg_arb_round_robin #(.reqs_p(reqs_p)) rr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (req_v_i),
    .yumi_i  (yumi),
    .pick_o  (pick),
    .v_o     (pick_v)
  );

  assign issue_ok             = !cache_req_busy_i && !cache_req_credits_full_i;
  assign pick_oh              = reqs_p'(1) << pick;
  assign grant_oh             = reqs_p'(1) << grant_q;
  assign cache_req_o          = req_arr[pick];
  assign cache_req_metadata_o = md_arr[grant_q];
  assign req_busy_o           = {reqs_p{reset_i | cache_req_busy_i | (state_q != e_arb_idle)}};

  always_comb begin
    state_d                = state_q;
    grant_d                = grant_q;
    yumi                   = 1'b0;
    cache_req_v_o          = 1'b0;
    req_ready_and_o        = '0;
    cache_req_metadata_v_o = 1'b0;
    req_critical_tag_o     = '0;
    req_critical_data_o    = '0;
    req_complete_o         = '0;
    if (!reset_i) begin
      case (state_q)
        e_arb_idle: begin
          cache_req_v_o = pick_v && issue_ok;
          if (cache_req_v_o && cache_req_ready_and_i) begin
            req_ready_and_o = pick_oh;
            yumi            = 1'b1;
            grant_d         = pick;
            state_d         = e_arb_meta;
          end
        end
        e_arb_meta: begin
          cache_req_metadata_v_o = req_metadata_v_i[grant_q];
          req_critical_tag_o     = grant_oh & {reqs_p{cache_req_critical_tag_i}};
          req_critical_data_o    = grant_oh & {reqs_p{cache_req_critical_data_i}};
          if (cache_req_metadata_v_o) begin
            state_d = e_arb_wait;
          end
        end
        e_arb_wait: begin
          req_critical_tag_o  = grant_oh & {reqs_p{cache_req_critical_tag_i}};
          req_critical_data_o = grant_oh & {reqs_p{cache_req_critical_data_i}};
          req_complete_o      = grant_oh & {reqs_p{cache_req_complete_i}};
          if (cache_req_complete_i) begin
            state_d = e_arb_idle;
          end
        end
        default: state_d = e_arb_idle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_arb_idle;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Metadata must trail the request handshake by at least one cycle.
  a_no_meta_on_issue: assert property (@(posedge clk_i) disable iff (reset_i)
    !(cache_req_v_o && cache_req_ready_and_i && req_metadata_v_i[pick]));

  a_complete_only_in_wait: assert property (@(posedge clk_i) disable iff (reset_i)
    cache_req_complete_i |-> (state_q == e_arb_wait));

endmodule

// File: tb/tb_bp_fe_cache_req_arbiter.sv
// Bench for bp_fe_cache_req_arbiter: directed vector table, reset-in-flight sequence, then random traffic vs. a transaction-level model.
module tb_bp_fe_cache_req_arbiter;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int MW = 4;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [N*W-1:0]  req_i;
  logic [N-1:0]    req_v_i;
  logic [N-1:0]    req_ready_and_o;
  logic [N*MW-1:0] req_metadata_i;
  logic [N-1:0]    req_metadata_v_i;
  logic [N-1:0]    req_busy_o;
  logic [N-1:0]    req_critical_tag_o;
  logic [N-1:0]    req_critical_data_o;
  logic [N-1:0]    req_complete_o;
  logic [W-1:0]    cache_req_o;
  logic            cache_req_v_o;
  logic            cache_req_ready_and_i;
  logic            cache_req_busy_i;
  logic [MW-1:0]   cache_req_metadata_o;
  logic            cache_req_metadata_v_o;
  logic            cache_req_critical_tag_i;
  logic            cache_req_critical_data_i;
  logic            cache_req_complete_i;
  logic            cache_req_credits_full_i;

  always #5 clk_i = ~clk_i;

  bp_fe_cache_req_arbiter #(.reqs_p(N), .req_width_p(W), .metadata_width_p(MW)) dut (
    .clk_i                     (clk_i),
    .reset_i                   (reset_i),
    .req_i                     (req_i),
    .req_v_i                   (req_v_i),
    .req_ready_and_o           (req_ready_and_o),
    .req_metadata_i            (req_metadata_i),
    .req_metadata_v_i          (req_metadata_v_i),
    .req_busy_o                (req_busy_o),
    .req_critical_tag_o        (req_critical_tag_o),
    .req_critical_data_o       (req_critical_data_o),
    .req_complete_o            (req_complete_o),
    .cache_req_o               (cache_req_o),
    .cache_req_v_o             (cache_req_v_o),
    .cache_req_ready_and_i     (cache_req_ready_and_i),
    .cache_req_busy_i          (cache_req_busy_i),
    .cache_req_metadata_o      (cache_req_metadata_o),
    .cache_req_metadata_v_o    (cache_req_metadata_v_o),
    .cache_req_critical_tag_i  (cache_req_critical_tag_i),
    .cache_req_critical_data_i (cache_req_critical_data_i),
    .cache_req_complete_i      (cache_req_complete_i),
    .cache_req_credits_full_i  (cache_req_credits_full_i)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] v;
    logic       rdy, bsy, cf;
    logic [1:0] mdv;
    logic       tg, dt, cm;
    logic       ev;
    logic [1:0] erdy;
    logic [7:0] epkt;
    logic       emdv;
    logic [3:0] emd;
    logic [1:0] etg, edt, ecm, ebsy;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic rdy, bsy, cf, input logic [1:0] mdv,
                              input logic tg, dt, cm, input logic ev, input logic [1:0] erdy,
                              input logic [7:0] epkt, input logic emdv, input logic [3:0] emd,
                              input logic [1:0] etg, edt, ecm, ebsy);
    vec_t r;
    r.v = v; r.rdy = rdy; r.bsy = bsy; r.cf = cf; r.mdv = mdv; r.tg = tg; r.dt = dt; r.cm = cm;
    r.ev = ev; r.erdy = erdy; r.epkt = epkt; r.emdv = emdv; r.emd = emd;
    r.etg = etg; r.edt = edt; r.ecm = ecm; r.ebsy = ebsy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tg, input logic ev, input logic [1:0] erdy, input logic [7:0] epkt,
                            input logic emdv, input logic [3:0] emd, input logic [1:0] etg, edt, ecm, ebsy);
    chk({tg, ".cache_req_v"}, 32'(cache_req_v_o), 32'(ev));
    chk({tg, ".ready_and"}, 32'(req_ready_and_o), 32'(erdy));
    if (ev) chk({tg, ".cache_req"}, 32'(cache_req_o), 32'(epkt));
    chk({tg, ".md_v"}, 32'(cache_req_metadata_v_o), 32'(emdv));
    if (emdv) chk({tg, ".md"}, 32'(cache_req_metadata_o), 32'(emd));
    chk({tg, ".crit_tag"}, 32'(req_critical_tag_o), 32'(etg));
    chk({tg, ".crit_data"}, 32'(req_critical_data_o), 32'(edt));
    chk({tg, ".complete"}, 32'(req_complete_o), 32'(ecm));
    chk({tg, ".busy"}, 32'(req_busy_o), 32'(ebsy));
  endtask

  task automatic drive(input logic [1:0] v, input logic rdy, bsy, cf, input logic [1:0] mdv,
                       input logic tg, dt, cm);
    req_v_i = v; cache_req_ready_and_i = rdy; cache_req_busy_i = bsy; cache_req_credits_full_i = cf;
    req_metadata_v_i = mdv; cache_req_critical_tag_i = tg; cache_req_critical_data_i = dt;
    cache_req_complete_i = cm;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl [22];

  // Transaction-level reference: who owns the engine, whether its metadata has gone, and who is next in line.
  int         owner;
  bit         md_done;
  int         prio;
  bit [1:0]   pend;
  logic [7:0] pdat [2];

  initial begin
    tbl[0]  = mk(2'b01,1,0,0,2'b00,0,0,0, 1,2'b01,8'hA0, 0,4'h0, 2'b00,2'b00,2'b00,2'b00);
    tbl[1]  = mk(2'b00,0,0,0,2'b01,0,0,0, 0,2'b00,8'h00, 1,4'h3, 2'b00,2'b00,2'b00,2'b11);
    tbl[2]  = mk(2'b00,0,0,0,2'b00,0,0,0, 0,2'b00,8'h00, 0,4'h0, 2'b00,2'b00,2'b00,2'b11);
    tbl[3]  = mk(2'b00,0,0,0,2'b00,0,0,1, 0,2'b00,8'h00, 0,4'h0, 2'b00,2'b00,2'b01,2'b11);
    tbl[4]  = mk(2'b11,1,0,0,2'b00,0,0,0, 1,2'b10,8'hB1, 0,4'h0, 2'b00,2'b00,2'b00,2'b00);
    tbl[5]  = mk(2'b01,0,0,0,2'b10,0,0,0, 0,2'b00,8'h00, 1,4'hC, 2'b00,2'b00,2'b00,2'b11);
    tbl[6]  = mk(2'b01,0,0,0,2'b00,1,0,0, 0,2'b00,8'h00, 0,4'h0, 2'b10,2'b00,2'b00,2'b11);
    tbl[7]  = mk(2'b01,0,0,0,2'b01,0,1,0, 0,2'b00,8'h00, 0,4'h0, 2'b00,2'b10,2'b00,2'b11);
    tbl[8]  = mk(2'b01,1,0,0,2'b00,0,0,1, 0,2'b00,8'h00, 0,4'h0, 2'b00,2'b00,2'b10,2'b11);
    tbl[9]  = mk(2'b11,1,0,0,2'b00,0,0,0, 1,2'b01,8'hA0, 0,4'h0, 2'b00,2'b00,2'b00,2'b00);
    tbl[10] = mk(2'b10,0,0,0,2'b01,0,0,0, 0,2'b00,8'h00, 1,4'h3, 2'b00,2'b00,2'b00,2'b11);
    tbl[11] = mk(2'b10,0,0,0,2'b00,0,0,1, 0,2'b00,8'h00, 0,4'h0, 2'b00,2'b00,2'b01,2'b11);
    tbl[12] = mk(2'b11,1,1,0,2'b00,0,0,0, 0,2'b00,8'h00, 0,4'h0, 2'b00,2'b00,2'b00,2'b11);
    tbl[13] = mk(2'b11,1,0,1,2'b00,0,0,0, 0,2'b00,8'h00, 0,4'h0, 2'b00,2'b00,2'b00,2'b00);
    tbl[14] = mk(2'b11,0,0,0,2'b00,0,0,0, 1,2'b00,8'hB1, 0,4'h0, 2'b00,2'b00,2'b00,2'b00);
    tbl[15] = mk(2'b11,1,0,0,2'b00,0,0,0, 1,2'b10,8'hB1, 0,4'h0, 2'b00,2'b00,2'b00,2'b00);
    tbl[16] = mk(2'b01,0,0,0,2'b10,1,0,0, 0,2'b00,8'h00, 1,4'hC, 2'b10,2'b00,2'b00,2'b11);
    tbl[17] = mk(2'b01,0,0,0,2'b00,0,0,1, 0,2'b00,8'h00, 0,4'h0, 2'b00,2'b00,2'b10,2'b11);
    tbl[18] = mk(2'b01,1,0,0,2'b00,0,0,0, 1,2'b01,8'hA0, 0,4'h0, 2'b00,2'b00,2'b00,2'b00);
    tbl[19] = mk(2'b00,0,0,0,2'b00,0,0,0, 0,2'b00,8'h00, 0,4'h0, 2'b00,2'b00,2'b00,2'b11);
    tbl[20] = mk(2'b00,0,0,0,2'b01,0,0,0, 0,2'b00,8'h00, 1,4'h3, 2'b00,2'b00,2'b00,2'b11);
    tbl[21] = mk(2'b00,0,0,0,2'b00,0,0,1, 0,2'b00,8'h00, 0,4'h0, 2'b00,2'b00,2'b01,2'b11);

    req_i          = {8'hB1, 8'hA0};
    req_metadata_i = {4'hC, 4'h3};
    reset_i        = 1'b1;
    drive(2'b00, 0, 0, 0, 2'b00, 0, 0, 0);

    // Reset state
    for (int c = 0; c < 2; c++) begin
      #2;
      check_outs("reset", 0, 2'b00, 8'h00, 0, 4'h0, 2'b00, 2'b00, 2'b00, 2'b11);
      tick();
    end
    reset_i = 1'b0;

    // Directed table
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].v, tbl[i].rdy, tbl[i].bsy, tbl[i].cf, tbl[i].mdv, tbl[i].tg, tbl[i].dt, tbl[i].cm);
      #2;
      check_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].erdy, tbl[i].epkt, tbl[i].emdv, tbl[i].emd,
                 tbl[i].etg, tbl[i].edt, tbl[i].ecm, tbl[i].ebsy);
      tick();
    end

    // Reset while port1 transaction is waiting on the engine; port0 must win afterwards.
    drive(2'b10, 1, 0, 0, 2'b00, 0, 0, 0);
    #2;
    check_outs("rst_issue", 1, 2'b10, 8'hB1, 0, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    drive(2'b00, 0, 0, 0, 2'b10, 0, 0, 0);
    #2;
    check_outs("rst_meta", 0, 2'b00, 8'h00, 1, 4'hC, 2'b00, 2'b00, 2'b00, 2'b11);
    tick();
    reset_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(2'b11, 1, 0, 0, 2'b00, 1, 1, 0);
      #2;
      check_outs("rst_mid", 0, 2'b00, 8'h00, 0, 4'h0, 2'b00, 2'b00, 2'b00, 2'b11);
      tick();
    end
    reset_i = 1'b0;
    drive(2'b11, 1, 0, 0, 2'b00, 0, 0, 0);
    #2;
    check_outs("rst_after", 1, 2'b01, 8'hA0, 0, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    reset_i = 1'b1;
    drive(2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
    tick();
    reset_i = 1'b0;

    // Random traffic against the transaction-level model
    owner = -1; md_done = 0; prio = 0; pend = 2'b00;
    pdat[0] = 8'h00; pdat[1] = 8'h00;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic       ok, found, ev, emdv, hs;
      logic [1:0] erdy, etg, edt, ecm, ebsy, mdv;
      logic [7:0] epkt;
      logic [3:0] emd;
      logic       rdy, bsy, cf, tg, dt, cm;
      int         pk;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          pdat[p] = 8'($urandom);
        end
      end
      req_i          = {pdat[1], pdat[0]};
      req_metadata_i = 8'($urandom);
      rdy = 1'($urandom);
      bsy = ($urandom_range(0, 3) == 0);
      cf  = ($urandom_range(0, 3) == 0);
      mdv = (owner >= 0 && !md_done) ? 2'($urandom) : 2'b00;
      tg  = (owner >= 0) ? 1'($urandom) : 1'b0;
      dt  = (owner >= 0) ? 1'($urandom) : 1'b0;
      cm  = (owner >= 0 && md_done) ? ($urandom_range(0, 2) == 0) : 1'b0;
      drive(pend, rdy, bsy, cf, mdv, tg, dt, cm);
      #2;
      ebsy = (owner >= 0 || bsy) ? 2'b11 : 2'b00;
      ev = 0; erdy = 2'b00; epkt = 8'h00; emdv = 0; emd = 4'h0;
      etg = 2'b00; edt = 2'b00; ecm = 2'b00; hs = 0; pk = 0;
      if (owner < 0) begin
        ok = !bsy && !cf;
        found = 0;
        for (int k = 0; k < 2; k++) begin
          int idx;
          idx = (prio + k) % 2;
          if (!found && pend[idx]) begin
            found = 1;
            pk = idx;
          end
        end
        ev   = found && ok;
        epkt = pdat[pk];
        hs   = ev && rdy;
        erdy = hs ? 2'(1 << pk) : 2'b00;
      end else begin
        etg = tg ? 2'(1 << owner) : 2'b00;
        edt = dt ? 2'(1 << owner) : 2'b00;
        if (!md_done) begin
          emdv = mdv[owner];
          emd  = owner == 0 ? req_metadata_i[3:0] : req_metadata_i[7:4];
        end else begin
          ecm = cm ? 2'(1 << owner) : 2'b00;
        end
      end
      check_outs($sformatf("rnd%0d", cyc), ev, erdy, epkt, emdv, emd, etg, edt, ecm, ebsy);
      if (owner < 0) begin
        if (hs) begin
          owner = pk; md_done = 0; prio = (pk + 1) % 2; pend[pk] = 1'b0;
        end
      end else if (!md_done) begin
        if (mdv[owner]) md_done = 1;
      end else if (cm) begin
        owner = -1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
